vcpu_sim_ctrl: RTL

//   Memory-mapped simulation controller on the vcore data bus, beside data_mem.

---
 rtl/vcpu_sim_ctrl_pkg.sv | 43 ++++
 rtl/vcpu_sim_ctrl_if.sv | 28 ++
 rtl/sim_ctrl_fifo.sv | 46 ++++
 rtl/vcpu_sim_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vcpu_sim_ctrl_pkg.sv
// Shared definitions for the vcore simulation controller: widths, register word offsets,
// STATUS bit layout, timeout fail code and FSM encoding.
package vcpu_sim_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CODE_W = 31;
    localparam int unsigned OFS_W  = 3;
    localparam int unsigned BYTE_W = 8;

    localparam logic [OFS_W-1:0] OFS_TOHOST  = 3'd0;
    localparam logic [OFS_W-1:0] OFS_CYCLE   = 3'd1;
    localparam logic [OFS_W-1:0] OFS_CONSOLE = 3'd2;
    localparam logic [OFS_W-1:0] OFS_STATUS  = 3'd3;
    localparam logic [OFS_W-1:0] OFS_WDOG    = 3'd4;

    localparam int unsigned ST_DONE     = 0;
    localparam int unsigned ST_WDOG_EXP = 1;
    localparam int unsigned ST_EMPTY    = 2;
    localparam int unsigned ST_FULL     = 3;
    localparam int unsigned ST_OVF      = 4;

    localparam logic [CODE_W-1:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Field order matches the STATUS register, done in bit 0
    typedef struct packed {
        logic ovf;
        logic full;
        logic empty;
        logic wdog_exp;
        logic done;
    } status_t;

    function automatic logic [DATA_W-1:0] status_word(input status_t s);
        return {27'd0, s};
    endfunction

endpackage

// File: rtl/vcpu_sim_ctrl_if.sv
// Data-bus access, run-status and console signals between the vcore side and the controller.
interface vcpu_sim_ctrl_if;
    import vcpu_sim_ctrl_pkg::*;

    logic              mem_en;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              hit;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              pass;
    logic [CODE_W-1:0] code;
    logic              finish;
    logic              con_valid;
    logic [BYTE_W-1:0] con_data;
    logic              con_ready;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata, con_ready,
        input  hit, rdata, done, pass, code, finish, con_valid, con_data
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata, con_ready,
        output hit, rdata, done, pass, code, finish, con_valid, con_data
    );
endinterface

// File: rtl/sim_ctrl_fifo.sv
// Console byte FIFO with wrapping (AW+1)-bit pointers; compiled only with SIM_CTRL_CONSOLE_EN.
`ifdef SIM_CTRL_CONSOLE_EN
module sim_ctrl_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0] wr_ptr, rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          push_ok, pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO still lands when the same cycle frees an entry
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule
`endif

// File: rtl/vcpu_sim_ctrl.sv
// Memory-mapped simulation controller: TOHOST pass/fail, cycle counter, watchdog and RUN/DRAIN/FINISH FSM.
// The console FIFO and con_* outputs exist only when SIM_CTRL_CONSOLE_EN is defined.
module vcpu_sim_ctrl
    import vcpu_sim_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYC = 250,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    vcpu_sim_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state, state_nxt;
    logic              done_nxt, pass_nxt, finish_nxt, wdog_exp, wdog_exp_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic [DATA_W-1:0] cycle_cnt, wdog_cnt, tohost, rd_val;
    logic              sel, wr_hit, rd_hit, in_run;
    logic              tohost_wr, wdog_wr, con_wr, wdog_fire;
    logic [OFS_W-1:0]  ofs;
    logic              ovf, fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    status_t           status;
    logic              unused_bits;

    assign sel       = bus.mem_en && (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
    assign ofs       = bus.mem_addr[4:2];
    assign wr_hit    = sel && bus.mem_wr;
    assign rd_hit    = sel && !bus.mem_wr;
    assign in_run    = (state == S_RUN);
    assign tohost_wr = wr_hit && (ofs == OFS_TOHOST) && in_run;
    assign wdog_wr   = wr_hit && (ofs == OFS_WDOG) && in_run;
    assign con_wr    = wr_hit && (ofs == OFS_CONSOLE);
    // A reload in the expiry cycle keeps the run alive
    assign wdog_fire = in_run && !wdog_wr && (wdog_cnt == 32'd1);
    assign unused_bits = ^{bus.mem_addr[1:0], bus.con_ready, con_wr};

`ifdef SIM_CTRL_CONSOLE_EN
    localparam bit CON_EN = 1'b1;
    logic              fifo_pop;
    logic [BYTE_W-1:0] fifo_head;

    assign fifo_pop = bus.con_ready && !fifo_empty;

    sim_ctrl_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (con_wr),
        .pop   (fifo_pop),
        .wdata (bus.mem_wdata[BYTE_W-1:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               ovf <= 1'b0;
        else if (con_wr && fifo_full && !fifo_pop) ovf <= 1'b1;
    end

    assign bus.con_valid = !fifo_empty;
    assign bus.con_data  = fifo_head;
`else
    localparam bit CON_EN = 1'b0;
    assign fifo_full     = 1'b0;
    assign fifo_empty    = 1'b1;
    assign fifo_count    = '0;
    assign ovf           = 1'b0;
    assign bus.con_valid = 1'b0;
    assign bus.con_data  = '0;
`endif

    // Register read mux
    always_comb begin
        status.ovf      = ovf;
        status.full     = fifo_full;
        status.empty    = fifo_empty;
        status.wdog_exp = wdog_exp;
        status.done     = bus.done;
        rd_val          = '0;
        case (ofs)
            OFS_TOHOST:  rd_val = tohost;
            OFS_CYCLE:   rd_val = cycle_cnt;
            OFS_CONSOLE: rd_val = CON_EN ? (32'(FIFO_DEPTH) - 32'(fifo_count)) : '0;
            OFS_STATUS:  rd_val = status_word(status);
            default:     rd_val = '0;
        endcase
    end

    // FSM next state and next values of the run-result outputs; TOHOST beats watchdog expiry
    always_comb begin
        state_nxt    = state;
        done_nxt     = bus.done;
        pass_nxt     = bus.pass;
        code_nxt     = bus.code;
        finish_nxt   = bus.finish;
        wdog_exp_nxt = wdog_exp;
        case (state)
            S_RUN: begin
                if (tohost_wr && (bus.mem_wdata != '0)) begin
                    state_nxt = S_DRAIN;
                    done_nxt  = 1'b1;
                    pass_nxt  = (bus.mem_wdata == 32'd1);
                    code_nxt  = bus.mem_wdata[31:1];
                end else if (wdog_fire) begin
                    state_nxt    = S_DRAIN;
                    done_nxt     = 1'b1;
                    pass_nxt     = 1'b0;
                    code_nxt     = TIMEOUT_CODE;
                    wdog_exp_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt  = S_FINISH;
                    finish_nxt = 1'b1;
                end
            end
            S_FINISH: state_nxt = S_FINISH;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RUN;
            bus.done   <= 1'b0;
            bus.pass   <= 1'b0;
            bus.code   <= '0;
            bus.finish <= 1'b0;
            bus.hit    <= 1'b0;
            bus.rdata  <= '0;
            wdog_exp   <= 1'b0;
            cycle_cnt  <= '0;
            wdog_cnt   <= 32'(TIMEOUT_CYC);
            tohost     <= '0;
        end else begin
            state      <= state_nxt;
            bus.done   <= done_nxt;
            bus.pass   <= pass_nxt;
            bus.code   <= code_nxt;
            bus.finish <= finish_nxt;
            wdog_exp   <= wdog_exp_nxt;
            bus.hit    <= sel;
            if (rd_hit)    bus.rdata <= rd_val;
            if (tohost_wr) tohost    <= bus.mem_wdata;
            // Counter and watchdog only advance while the run is live
            if (in_run) begin
                cycle_cnt <= cycle_cnt + 32'd1;
                if (wdog_wr)              wdog_cnt <= 32'(TIMEOUT_CYC);
                else if (wdog_cnt != '0)  wdog_cnt <= wdog_cnt - 32'd1;
            end
        end
    end

endmodule
